// File: rtl/lii_out_arbiter.sv
// ---------------------------------------------------------------------------
// lii_out_arbiter
//   Round-robin arbiter that shares one LII phy output channel among N
//   logical kernel output streams. Once a stream wins, it keeps the channel
//   for a burst of up to BURST beats, so bursts from different streams never
//   interleave. Each burst is tagged with a constant source id and with the
//   winner's destination id, which is captured when the grant is made.
//
// Ports
//   aclk      clock, all logic on the rising edge
//   arstn     asynchronous active-low reset (released synchronously upstream)
//   s_tdata   N*PW  requester data, stream i at [i*PW +: PW]
//   s_tvalid  N     requester valid
//   s_tready  N     requester ready, one-hot or zero
//   s_dst     N*8   requester destination id, stream i at [i*8 +: 8]
//   m_tdata   PW    phy output data (registered)
//   m_tvalid  1     phy output valid (registered)
//   m_tready  1     phy output ready
//   m_src     8     constant SRC_ID
//   m_dst     8     destination id of the current burst (registered)
//   grant     N     one-hot current owner, zero while idle
//   busy      1     high while a burst is locked (FSM state: LOCK)
//
// Handshake: a beat moves on a channel exactly in a cycle where valid and
// ready are both high at the rising edge. A source may not retract data it
// has presented while valid & !ready; m_tdata/m_dst hold steady while
// m_tvalid & !m_tready.
// ---------------------------------------------------------------------------
module lii_out_arbiter #(
  parameter int          N      = 4,
  parameter int          PW     = 128,
  parameter int          BURST  = 16,
  parameter logic [7:0]  SRC_ID = 8'h00
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [N*PW-1:0]   s_tdata,
  input  logic [N-1:0]      s_tvalid,
  output logic [N-1:0]      s_tready,
  input  logic [N*8-1:0]    s_dst,
  output logic [PW-1:0]     m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [7:0]        m_src,
  output logic [7:0]        m_dst,
  output logic [N-1:0]      grant,
  output logic              busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [IW-1:0]   last;      // index of the most recent winner; while LOCKed it is the owner
  logic [CW-1:0]   beat_cnt;

  logic            slot_free;
  logic            cur_valid;
  logic            accept;
  logic            release_burst;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;

  // Output register can take a new beat when empty or draining this cycle.
  assign slot_free = !m_tvalid || m_tready;
  assign cur_valid = s_tvalid[last];
  assign accept    = (state == LOCK) && cur_valid && slot_free;

  // Burst ends on its BURST-th beat, or as soon as the owner has nothing to
  // offer while the output could have taken a beat.
  assign release_burst = (accept && (beat_cnt == LAST_BEAT)) ||
                         (slot_free && !cur_valid);

  assign m_src = SRC_ID;
  assign busy  = (state == LOCK);

  always_comb begin
    s_tready = '0;
    if (state == LOCK && slot_free) begin
      s_tready = ONE_N << last;
    end
  end

  // Round-robin scan starting just after the previous winner, wrapping at N.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (!pick_found && s_tvalid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      last     <= IW'(N - 1);
      beat_cnt <= '0;
      grant    <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_dst    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A beat left over from the previous burst drains here.
          if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
          end
          // m_dst must not change under a waiting beat, so a new grant also
          // waits until the output register is free.
          if (pick_found && slot_free) begin
            grant    <= ONE_N << pick_idx;
            last     <= pick_idx;
            m_dst    <= s_dst[int'(pick_idx)*8 +: 8];
            beat_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (accept) begin
            m_tdata  <= s_tdata[int'(last)*PW +: PW];
            m_tvalid <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
          end else if (m_tready) begin
            m_tvalid <= 1'b0;
          end
          if (release_burst) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
